// File: rtl/pixel_sink_pkg.sv
// Shared types and constants for the pixel write sink: screen geometry, the pixel record,
// the sink state enum and coordinate helpers.
package pixel_sink_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned FB_SIZE  = 19200;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // y*160 + x as two shifts and an add; fits 15 bits even for out-of-range inputs.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 7) + (yw << 5) + ADDR_W'(x);
    endfunction

    function automatic logic pixel_in_range(input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Plot handshake bus between the drawers (master) and the pixel write sink (slave).
interface pixel_write_sink_if;
    import pixel_sink_pkg::*;

    logic [X_W-1:0]     XIn;
    logic [Y_W-1:0]     YIn;
    logic [COLOR_W-1:0] ColorIn;
    logic               Plot;
    logic               Ready;

    modport master (output XIn, YIn, ColorIn, Plot, input Ready);
    modport slave  (input XIn, YIn, ColorIn, Plot, output Ready);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel records; pushes when full and pops when empty are ignored.
module pixel_fifo
    import pixel_sink_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic   Clock,
    input  logic   Reset,
    input  logic   push,
    input  logic   pop,
    input  pixel_t wdata,
    output pixel_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    pixel_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers plots, linearises them into framebuffer writes and sequences full-screen clears.
// Optional clipping of off-screen plots is enabled by defining PIXEL_SINK_CLIP_EN.
module pixel_write_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH  = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    pixel_write_sink_if.slave     plot_bus,
    input  logic                  ClearReq,
    output logic                  ClearBusy,
    output logic [ADDR_W-1:0]     MemAddr,
    output logic [COLOR_W-1:0]    MemData,
    output logic                  MemWe,
    input  logic                  MemStall,
    output logic [7:0]            DropCount
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q;
    logic               clr_last;
    logic               ready;
    logic               plot_fire, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic               clr_start, clr_step, load_idle;
    pixel_t             fifo_wdata, fifo_head;

    assign fifo_wdata = '{x: plot_bus.XIn, y: plot_bus.YIn, color: plot_bus.ColorIn};
    assign plot_fire  = plot_bus.Plot && ready;
    assign plot_bus.Ready = ready;
    assign clr_last   = (clr_cnt_q == ADDR_W'(FB_SIZE - 1));

`ifdef PIXEL_SINK_CLIP_EN
    logic       in_bounds;
    logic [7:0] drop_q;

    assign in_bounds = pixel_in_range(plot_bus.XIn, plot_bus.YIn);
    assign fifo_push = plot_fire && in_bounds;
    assign DropCount = drop_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            drop_q <= '0;
        end else if (plot_fire && !in_bounds && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end
`else
    assign fifo_push = plot_fire;
    assign DropCount = '0;
`endif

    pixel_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (ClearReq && !MemStall) state_d = CLEAR;
            CLEAR: if (!MemStall && clr_last) state_d = RUN;
        endcase
    end

    // A clear request wins over draining on the transition edge so the FIFO is kept intact.
    always_comb begin
        ready     = 1'b0;
        ClearBusy = 1'b0;
        fifo_pop  = 1'b0;
        clr_start = 1'b0;
        clr_step  = 1'b0;
        load_idle = 1'b0;
        unique case (state_q)
            RUN: begin
                ready     = !fifo_full;
                clr_start = ClearReq && !MemStall;
                fifo_pop  = !ClearReq && !MemStall && !fifo_empty;
                load_idle = !MemStall && (ClearReq || fifo_empty);
            end
            CLEAR: begin
                ClearBusy = 1'b1;
                clr_step  = !MemStall;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clr_cnt_q <= '0;
        end else if (clr_start) begin
            clr_cnt_q <= '0;
        end else if (clr_step) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    // Output stage: no enable is asserted under stall, so address, data and strobe hold.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MemAddr <= '0;
            MemData <= '0;
            MemWe   <= 1'b0;
        end else if (clr_step) begin
            MemAddr <= clr_cnt_q;
            MemData <= CLEAR_COLOR;
            MemWe   <= 1'b1;
        end else if (fifo_pop) begin
            MemAddr <= pixel_addr(fifo_head.x, fifo_head.y);
            MemData <= fifo_head.color;
            MemWe   <= 1'b1;
        end else if (load_idle) begin
            MemWe   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink; writes are logged from the memory port.
module tb_pixel_write_sink;
    import pixel_sink_pkg::*;

    localparam logic [2:0] CLR_COL = 3'b000;

    logic        Clock = 1'b0;
    logic        Reset, ClearReq, ClearBusy, MemWe, MemStall;
    logic [14:0] MemAddr;
    logic [2:0]  MemData;
    logic [7:0]  DropCount;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] wq[$];

    pixel_write_sink_if pbus ();

    pixel_write_sink #(
        .FIFO_DEPTH  (8),
        .CLEAR_COLOR (CLR_COL)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .plot_bus  (pbus),
        .ClearReq  (ClearReq),
        .ClearBusy (ClearBusy),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemWe     (MemWe),
        .MemStall  (MemStall),
        .DropCount (DropCount)
    );

    always #5 Clock = ~Clock;

    // A write is taken by memory at the rising edge where MemWe is high and MemStall low.
    always @(negedge Clock) begin
        if (!Reset && MemWe && !MemStall) wq.push_back({MemAddr, MemData});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input bit p, input int x, input int y, input int c);
        pbus.Plot    = p;
        pbus.XIn     = 8'(x);
        pbus.YIn     = 7'(y);
        pbus.ColorIn = 3'(c);
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n, bad;
        Reset    = 1'b1;
        MemStall = 1'b0;
        ClearReq = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready",     32'(pbus.Ready), 1);
        check("rst_clearbusy", 32'(ClearBusy), 0);
        check("rst_memwe",     32'(MemWe), 0);
        check("rst_memaddr",   32'(MemAddr), 0);
        check("rst_memdata",   32'(MemData), 0);
        check("rst_dropcount", 32'(DropCount), 0);
        Reset = 1'b0;
        tick();

        // Single plot latency: accepted at edge k, written after edge k+1.
        wq.delete();
        drive(1, 5, 2, 3);
        tick();
        drive(0, 0, 0, 0);
        check("lat_edge_k_we", 32'(MemWe), 0);
        tick();
        check("lat_we",   32'(MemWe), 1);
        check("lat_addr", 32'(MemAddr), 325);
        check("lat_data", 32'(MemData), 3);
        tick();
        check("lat_pulse_end", 32'(MemWe), 0);

        // Fill under stall, then release and drain in order.
        MemStall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 0, i);
            tick();
        end
        drive(1, 8, 0, 0);
        check("stall_full_ready", 32'(pbus.Ready), 0);
        check("stall_we_held",    32'(MemWe), 0);
        tick();
        drive(0, 0, 0, 0);
        wq.delete();
        MemStall = 1'b0;
        repeat (12) tick();
        check("stall_write_count", 32'(wq.size()), 8);
        for (int i = 0; i < 8; i++) check("stall_order", wq_at(i), 32'({15'(i), 3'(i)}));

        // Corner coordinates.
        wq.delete();
        drive(1, 159, 119, 7);
        tick();
        drive(1, 160, 0, 5);
        check("clip_handshake_ready", 32'(pbus.Ready), 1);
        tick();
        drive(0, 0, 0, 0);
        repeat (5) tick();
        check("corner_addr", wq_at(0), 32'({15'd19199, 3'd7}));
`ifdef PIXEL_SINK_CLIP_EN
        check("clip_write_count", 32'(wq.size()), 1);
        check("clip_dropcount",   32'(DropCount), 1);
`else
        check("noclip_write_count", 32'(wq.size()), 2);
        check("noclip_addr",        wq_at(1), 32'({15'd160, 3'd5}));
`endif

        // Clear with two plots retained in the FIFO.
        MemStall = 1'b1;
        drive(1, 10, 1, 2);
        tick();
        drive(1, 20, 3, 4);
        tick();
        drive(0, 0, 0, 0);
        ClearReq = 1'b1;
        MemStall = 1'b0;
        wq.delete();
        tick();
        ClearReq = 1'b0;
        check("clr_busy_start", 32'(ClearBusy), 1);
        check("clr_ready_low",  32'(pbus.Ready), 0);
        n   = 0;
        bad = 0;
        while (ClearBusy && n < 20000) begin
            if (pbus.Ready) bad++;
            n++;
            tick();
        end
        check("clr_busy_cycles", 32'(n), 19200);
        check("clr_ready_during", 32'(bad), 0);
        repeat (6) tick();
        check("clr_write_count", 32'(wq.size()), 19202);
        bad = 0;
        for (int i = 0; i < 19200 && i < wq.size(); i++) begin
            if (wq[i] !== {15'(i), CLR_COL}) bad++;
        end
        check("clr_writes", 32'(bad), 0);
        check("clr_then_plot0", wq_at(19200), 32'({15'd170, 3'd2}));
        check("clr_then_plot1", wq_at(19201), 32'({15'd500, 3'd4}));

        // Reset in the middle of a clear with a buffered plot.
        MemStall = 1'b1;
        drive(1, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        ClearReq = 1'b1;
        MemStall = 1'b0;
        tick();
        ClearReq = 1'b0;
        n = 0;
        while (MemAddr != 15'd1000 && n < 2000) begin
            n++;
            tick();
        end
        check("rstclr_reach_1000", 32'(MemAddr), 1000);
        Reset = 1'b1;
        #1;
        check("rstclr_memwe",     32'(MemWe), 0);
        check("rstclr_clearbusy", 32'(ClearBusy), 0);
        check("rstclr_ready",     32'(pbus.Ready), 1);
        tick();
        Reset = 1'b0;
        wq.delete();
        repeat (20) tick();
        check("rstclr_no_writes", 32'(wq.size()), 0);

        // Simultaneous push and pop at occupancy 4.
        MemStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 4, i);
            tick();
        end
        check("pp_fill_count", 32'(dut.u_fifo.count_q), 4);
        wq.delete();
        MemStall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 4 + i, 4, 4 + i);
            tick();
            check("pp_count", 32'(dut.u_fifo.count_q), 4);
        end
        drive(0, 0, 0, 0);
        repeat (10) tick();
        check("pp_write_count", 32'(wq.size()), 24);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (wq_at(i) !== 32'({15'(640 + i), 3'(i)})) bad++;
        end
        check("pp_order", 32'(bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_sink.md
# pixel_write_sink

Receiving end of the pixel-plot interface driven by the character, obstacle and background drawers. Accepts one (X, Y, Color) plot per cycle and buffers it in a small FIFO. Linearises each coordinate into a framebuffer address and drives the framebuffer write port, honouring memory back-pressure. Also provides a full-screen clear sequencer that shares the same write port.

## Interface
Parameters:
- FIFO_DEPTH, 8, plot buffer entries (power of two).
- CLEAR_COLOR, 3'b000, colour written by the clear sequencer.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- XIn  in  8  plot column, valid 0..159.
- YIn  in  7  plot row, valid 0..119.
- ColorIn  in  3  plot colour.
- Plot  in  1  plot request; transfer occurs on an edge where Plot && Ready.
- Ready  out  1  sink can accept a plot this cycle.
- ClearReq  in  1  request full-screen clear (level, sampled per rules below).
- ClearBusy  out  1  clear sequence in progress.
- MemAddr  out  15  framebuffer address.
- MemData  out  3  framebuffer write colour.
- MemWe  out  1  framebuffer write strobe.
- MemStall  in  1  memory cannot take a write; output stage holds.
- DropCount  out  8  saturating count of clipped plots.

## Operation
- States: RUN, CLEAR.
- Ready = (state == RUN) && FIFO not full. It is combinational from registered state.
- Address = YIn*160 + XIn, computed as (Y<<7)+(Y<<5)+X. The result is 15 bits; maximum 19199.
- RUN: FIFO non-empty and MemStall low means pop one entry and load the output stage with MemWe=1. FIFO empty and MemStall low means MemWe=0.
- MemStall high: MemAddr, MemData and MemWe hold their values; no pop; the clear counter does not advance.
- Order is preserved; exactly one memory write per accepted in-range plot.
- Simultaneous push and pop with a non-full FIFO: count is unchanged and both take effect.
- RUN to CLEAR: ClearReq high and MemStall low on an edge in RUN. The clear counter loads 0.
  - FIFO contents are retained.
  - Ready drops in the cycle after the transition.
- CLEAR: each non-stalled edge loads MemAddr=counter, MemData=CLEAR_COLOR, MemWe=1, and increments the counter.
- CLEAR to RUN: on the edge that loads address 19199. Draining of retained FIFO entries resumes on the next edge.
- ClearReq while in CLEAR is ignored; no re-start and no queuing.
- ClearBusy = (state == CLEAR).

## Timing
- Reset values: Ready=1 (RUN, FIFO empty), ClearBusy=0, MemWe=0, MemAddr=0, MemData=0, DropCount=0. The FIFO pointers are emptied.
- Reset takes effect immediately, including mid-clear and mid-drain. In-flight and buffered plots are discarded.
- Latency: a plot accepted at edge k appears with MemWe=1 after edge k+1, provided there is no stall and no earlier backlog.
- Throughput: one write per cycle in steady state.
- Clear with no stalls: ClearBusy is high for exactly 19200 cycles, with 19200 consecutive MemWe pulses at addresses 0..19199.

## Configuration
- PIXEL_SINK_CLIP_EN defined:
  - An accepted plot with XIn>=160 or YIn>=120 completes the handshake but is not written to the FIFO.
  - DropCount increments and saturates at 255.
- PIXEL_SINK_CLIP_EN undefined:
  - No range check; every accepted plot is written at its computed address.
  - DropCount is tied to 0.

## Structure
- Shared package pixel_sink_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, FB_SIZE=19200, ADDR_W=15, COLOR_W=3.
  - The pixel record typedef (x, y, color).
  - The state enum (RUN, CLEAR).
- One sub-module, pixel_fifo: synchronous FIFO with push/pop/full/empty and a FIFO_DEPTH parameter, storing the pixel record.
- Address computation, output stage and clear FSM live in pixel_write_sink.

## Test plan
- Reset, then plot X=5 Y=2 Color=3 -> one MemWe pulse after the second edge, MemAddr=325, MemData=3.
- MemStall high, Plot held for 9 cycles with X=0..8 Y=0 -> 8 plots accepted and Ready low on the 9th. Release the stall -> 8 writes at addresses 0..7 in order.
- Plot X=159 Y=119 -> MemAddr=19199. Plot X=160 Y=0:
  - with the macro, handshake completes, no MemWe, DropCount=1;
  - without the macro, MemAddr=160.
- Queue 2 plots under stall, pulse ClearReq, release the stall:
  - Phase 1: ClearBusy high and Ready low for 19200 cycles, writes to 0..19199 with CLEAR_COLOR.
  - Phase 2: the 2 queued plots are written next.
- Assert Reset at clear address 1000 -> MemWe=0, ClearBusy=0, Ready=1 immediately; no further writes after release.
- Push and pop on the same cycle at FIFO count 4 for 20 cycles -> count stays 4, every plot written once, in order.
